// File: rtl/bsg_mesh_out_port_sched_if.sv
// Handshake bundle between the input-side FIFOs, the output-port
// scheduler and the downstream ready_and link.
interface bsg_mesh_out_port_sched_if #(
  parameter int reqs_p = 5
);
  localparam int id_w_lp = (reqs_p > 1) ? $clog2(reqs_p) : 1;

  logic [reqs_p-1:0]  v_i;
  logic [reqs_p-1:0]  yumi_o;
  logic [reqs_p-1:0]  sel_one_hot_o;
  logic [id_w_lp-1:0] grant_id_o;
  logic               v_o;
  logic               ready_and_i;
  logic               starve_o;

  // requester/link side: drives valids and downstream ready
  modport master (
    output v_i, ready_and_i,
    input  yumi_o, sel_one_hot_o, grant_id_o, v_o, starve_o
  );

  // scheduler side
  modport slave (
    input  v_i, ready_and_i,
    output yumi_o, sel_one_hot_o, grant_id_o, v_o, starve_o
  );
endinterface

// File: rtl/bsg_mesh_out_port_sched.sv
// Output-port scheduler: round-robin among valid inputs, with a
// starvation override that hands the port to the lowest-index requester
// whose wait counter has saturated. Grant is combinational.
// Optional statistics: define BSG_MESH_OUT_SCHED_STATS_EN.
module bsg_mesh_out_port_sched #(
  parameter int reqs_p          = 5,
  parameter int starve_thresh_p = 15,
  parameter int stat_width_p    = 16
) (
  input  logic clk_i,
  input  logic reset_n_i,
  bsg_mesh_out_port_sched_if.slave bus
`ifdef BSG_MESH_OUT_SCHED_STATS_EN
  ,
  output logic [reqs_p-1:0][stat_width_p-1:0] grant_cnt_o,
  output logic [stat_width_p-1:0]             stall_cnt_o,
  output logic [stat_width_p-1:0]             starve_cnt_o
`endif
);
  localparam int id_w_lp   = (reqs_p > 1) ? $clog2(reqs_p) : 1;
  localparam int wait_w_lp = $clog2(starve_thresh_p + 1);
  localparam logic [wait_w_lp-1:0] thresh_lp = wait_w_lp'(starve_thresh_p);

  logic [id_w_lp-1:0]   r_last;
  logic [wait_w_lp-1:0] r_wait [reqs_p];

  logic [reqs_p-1:0]  w_sat;
  logic [reqs_p-1:0]  w_oh;
  logic [id_w_lp-1:0] w_gid;
  logic               w_any, w_ovr, w_xfer, w_found;
  int                 w_j;

  // requesters that are valid and have waited the full threshold
  always_comb begin
    w_sat = '0;
    for (int k = 0; k < reqs_p; k++)
      w_sat[k] = bus.v_i[k] && (r_wait[k] == thresh_lp);
  end

  assign w_any  = |bus.v_i;
  assign w_ovr  = |w_sat;
  assign w_xfer = w_any & bus.ready_and_i;

  // winner pick: lowest saturated index, else rotate upward from last+1
  always_comb begin
    w_gid   = '0;
    w_found = 1'b0;
    w_j     = 0;
    if (w_ovr) begin
      for (int k = 0; k < reqs_p; k++)
        if (w_sat[k] && !w_found) begin
          w_gid   = id_w_lp'(k);
          w_found = 1'b1;
        end
    end else begin
      for (int i = 1; i <= reqs_p; i++) begin
        w_j = int'(r_last) + i;
        if (w_j >= reqs_p) w_j = w_j - reqs_p;
        if (bus.v_i[w_j] && !w_found) begin
          w_gid   = id_w_lp'(w_j);
          w_found = 1'b1;
        end
      end
    end
    w_oh = '0;
    if (w_any) w_oh[w_gid] = 1'b1;
  end

  // all outputs are forced low in any reset cycle, not just after the edge
  assign bus.v_o           = reset_n_i & w_any;
  assign bus.sel_one_hot_o = reset_n_i ? w_oh : '0;
  assign bus.grant_id_o    = (reset_n_i && w_any) ? w_gid : '0;
  assign bus.yumi_o        = (reset_n_i && w_xfer) ? w_oh : '0;
  assign bus.starve_o      = reset_n_i & w_ovr;

  // pointer advances to the winner only when a flit actually moves
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)  r_last <= id_w_lp'(reqs_p - 1);
    else if (w_xfer) r_last <= w_gid;
  end

  // per-requester saturating wait counters; cleared on yumi or dropped valid
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < reqs_p; k++) begin
      if (!reset_n_i || !bus.v_i[k] || (w_xfer && w_oh[k]))
        r_wait[k] <= '0;
      else if (r_wait[k] != thresh_lp)
        r_wait[k] <= r_wait[k] + wait_w_lp'(1);
    end
  end

`ifdef BSG_MESH_OUT_SCHED_STATS_EN
  localparam logic [stat_width_p-1:0] sat_lp = '1;

  // saturating transfer / stall / override-win counters
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < reqs_p; k++) grant_cnt_o[k] <= '0;
      stall_cnt_o  <= '0;
      starve_cnt_o <= '0;
    end else begin
      for (int k = 0; k < reqs_p; k++)
        if (w_xfer && w_oh[k] && grant_cnt_o[k] != sat_lp)
          grant_cnt_o[k] <= grant_cnt_o[k] + 1'b1;
      if (w_any && !bus.ready_and_i && stall_cnt_o != sat_lp)
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (w_xfer && w_ovr && starve_cnt_o != sat_lp)
        starve_cnt_o <= starve_cnt_o + 1'b1;
    end
  end
`else
  // counter width only sizes the statistics ports; keep it referenced
  if (stat_width_p < 1) begin : g_no_stats
  end
`endif
endmodule

// File: tb/tb_bsg_mesh_out_port_sched.sv
// Randomized + directed bench for bsg_mesh_out_port_sched (reqs_p=5,
// starve_thresh_p=4) against a cycle-level reference model.
module tb_bsg_mesh_out_port_sched;
  localparam int N = 5;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bsg_mesh_out_port_sched_if #(.reqs_p(N)) bus ();

  bsg_mesh_out_port_sched #(.reqs_p(N), .starve_thresh_p(T), .stat_width_p(16)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // reference state: pointer and per-requester wait counts
  int m_last;
  int m_wait [N];

  // last observed / expected values, for directed checks
  int          o_grant;
  logic [N-1:0] o_yumi;
  logic        o_starve;
  logic [N-1:0] e_yumi;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic rdy, input logic rn);
    int   g;
    bit   any, ovr, found, vo, xfer;
    logic [N-1:0] sel, yumi;
    @(negedge clk);
    bus.v_i = v;
    bus.ready_and_i = rdy;
    rst_n = rn;
    #1;
    // model: starving requesters first (lowest index), else rotate from last+1
    any = |v; ovr = 0; found = 0; g = 0;
    for (int k = 0; k < N; k++)
      if (v[k] && m_wait[k] == T && !ovr) begin g = k; ovr = 1; end
    if (!ovr)
      for (int i = 1; i <= N; i++)
        if (!found && v[(m_last + i) % N]) begin g = (m_last + i) % N; found = 1; end
    vo   = rn && any;
    xfer = vo && rdy;
    sel  = vo ? (N'(1) << g) : '0;
    yumi = xfer ? sel : '0;
    chk("v_o",      32'(bus.v_o),           32'(vo));
    chk("sel",      32'(bus.sel_one_hot_o), 32'(sel));
    chk("grant_id", 32'(bus.grant_id_o),    vo ? 32'(g) : 32'd0);
    chk("yumi",     32'(bus.yumi_o),        32'(yumi));
    chk("starve",   32'(bus.starve_o),      32'(rn && ovr));
    o_grant  = int'(bus.grant_id_o);
    o_yumi   = bus.yumi_o;
    o_starve = bus.starve_o;
    e_yumi   = yumi;
    // model state update at the coming edge
    if (!rn) begin
      m_last = N - 1;
      for (int k = 0; k < N; k++) m_wait[k] = 0;
    end else begin
      for (int k = 0; k < N; k++)
        if (!v[k] || yumi[k]) m_wait[k] = 0;
        else m_wait[k] = (m_wait[k] + 1 > T) ? T : m_wait[k] + 1;
      if (xfer) m_last = g;
    end
  endtask

  initial begin
    logic [N-1:0] rv;
    rst_n = 1'b0;
    bus.v_i = '0;
    bus.ready_and_i = 1'b0;
    m_last = N - 1;
    for (int k = 0; k < N; k++) m_wait[k] = 0;

    // reset with everything requesting: outputs stay low
    for (int i = 0; i < 3; i++) step(5'b11111, 1'b1, 1'b0);
    chk("rst_yumi", 32'(o_yumi), 32'd0);

    // round-robin with all valid
    for (int i = 0; i < 10; i++) begin
      step(5'b11111, 1'b1, 1'b1);
      chk("rr_seq", 32'(o_grant), 32'(i % N));
    end

    // backpressure: grant held at 1, no yumi, then 1 then 2 drain
    step(5'b11111, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(5'b00110, 1'b0, 1'b1);
      chk("bp_hold", 32'(o_grant), 32'd1);
    end
    step(5'b00110, 1'b1, 1'b1);
    chk("bp_yumi1", 32'(o_yumi), 32'h02);
    step(5'b00100, 1'b1, 1'b1);
    chk("bp_yumi2", 32'(o_yumi), 32'h04);

    // starvation: req 4 stalls T cycles, then wins over pointer-favoured req 0
    step(5'b00000, 1'b0, 1'b0);
    for (int i = 0; i < T; i++) step(5'b10000, 1'b0, 1'b1);
    step(5'b10011, 1'b1, 1'b1);
    chk("ovr_grant", 32'(o_grant), 32'd4);
    chk("ovr_starve", 32'(o_starve), 32'd1);

    // early drop clears the wait count
    step(5'b00000, 1'b0, 1'b0);
    step(5'b00100, 1'b0, 1'b1);
    step(5'b00100, 1'b0, 1'b1);
    step(5'b00000, 1'b0, 1'b1);
    for (int i = 0; i < T; i++) begin
      step(5'b00100, 1'b0, 1'b1);
      chk("drop_starve", 32'(o_starve), 32'd0);
    end

    // randomized: valids mostly held until yumi, random ready and resets
    rv = '0;
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] nv;
      for (int k = 0; k < N; k++)
        if (rv[k] && !e_yumi[k]) nv[k] = ($urandom_range(0, 15) != 0);
        else                     nv[k] = $urandom_range(0, 1) != 0;
      rv = nv;
      step(rv, ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
